// File: rtl/hit_stream_writer_pkg.sv
// Shared ray-tracer types for the per-triangle hit-record stream.
// The writer and the accumulate stage both import this package.
package hit_stream_writer_pkg;

    localparam int DEF_D_BITS = 32;
    localparam int DEF_Q_BITS = 10;
    localparam int DEF_M_BITS = 12;

    typedef struct packed {
        logic                           hit;
        logic [2:0][DEF_D_BITS-1:0]     p_hit;
        logic [DEF_M_BITS-1:0]          triangle_ID;
    } hit_rec_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        FLUSH
    } hws_state_e;

endpackage

// File: rtl/hit_stream_writer_if.sv
// Ray FIFO, intersection engine and record FIFO signals of the writer.
// master = writer side, slave = the surrounding FIFOs and engine.
interface hit_stream_writer_if #(
    parameter int D_BITS = 32,
    parameter int M_BITS = 12
);

    logic                     ray_empty;
    logic                     ray_rd_en;

    logic                     isect_start;
    logic [M_BITS-1:0]        isect_tri_id;
    logic                     isect_done;
    logic                     isect_hit;
    logic [2:0][D_BITS-1:0]   isect_p_hit;

    logic                     out_full;
    logic                     out_wr_en;
    logic                     out_hit;
    logic [2:0][D_BITS-1:0]   out_p_hit;
    logic [M_BITS-1:0]        out_triangle_ID;

    modport master (
        input  ray_empty,
        output ray_rd_en,
        output isect_start,
        output isect_tri_id,
        input  isect_done,
        input  isect_hit,
        input  isect_p_hit,
        input  out_full,
        output out_wr_en,
        output out_hit,
        output out_p_hit,
        output out_triangle_ID
    );

    modport slave (
        output ray_empty,
        input  ray_rd_en,
        input  isect_start,
        input  isect_tri_id,
        output isect_done,
        output isect_hit,
        output isect_p_hit,
        output out_full,
        input  out_wr_en,
        input  out_hit,
        input  out_p_hit,
        input  out_triangle_ID
    );

endinterface

// File: rtl/hit_stream_writer.sv
// Hit-record producer: sweeps every triangle for each popped ray and
// writes one {hit, p_hit, ID} record per triangle, plus flush records.
module hit_stream_writer
    import hit_stream_writer_pkg::*;
#(
    parameter int D_BITS  = DEF_D_BITS,
    parameter int Q_BITS  = DEF_Q_BITS,
    parameter int M_BITS  = DEF_M_BITS,
    parameter int NUM_TRI = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    output logic busy,
    hit_stream_writer_if.master bus
);

    typedef logic [2:0][D_BITS-1:0] p3_t;

    localparam logic [M_BITS-1:0] LAST_TRI = M_BITS'(NUM_TRI - 1);

    // p_hit is carried through untouched, so Q_BITS only has to fit
    if (Q_BITS >= D_BITS) begin : g_q_bits_exceeds_d_bits
    end

    hws_state_e         state_q, state_d;
    logic [M_BITS-1:0]  tri_cnt_q, tri_cnt_d;
    logic               flush_done_q, flush_done_d;
    logic               hit_q, hit_d;
    p3_t                p_hit_q, p_hit_d;
    logic               rec_hit_q, rec_hit_d;
    p3_t                rec_p_q, rec_p_d;
    logic [M_BITS-1:0]  rec_id_q, rec_id_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            tri_cnt_q    <= '0;
            flush_done_q <= 1'b0;
            hit_q        <= 1'b0;
            p_hit_q      <= '0;
            rec_hit_q    <= 1'b0;
            rec_p_q      <= '0;
            rec_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            tri_cnt_q    <= tri_cnt_d;
            flush_done_q <= flush_done_d;
            hit_q        <= hit_d;
            p_hit_q      <= p_hit_d;
            rec_hit_q    <= rec_hit_d;
            rec_p_q      <= rec_p_d;
            rec_id_q     <= rec_id_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tri_cnt_d    = tri_cnt_q;
        flush_done_d = flush_done_q;
        hit_d        = hit_q;
        p_hit_d      = p_hit_q;
        rec_hit_d    = rec_hit_q;
        rec_p_d      = rec_p_q;
        rec_id_d     = rec_id_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.ray_empty) begin
                    state_d      = ISSUE;
                    tri_cnt_d    = '0;
                    flush_done_d = 1'b0;
                end else if (flush && !flush_done_q) begin
                    state_d = FLUSH;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.isect_done) begin
                    state_d = WRITE;
                    hit_d   = bus.isect_hit;
                    p_hit_d = bus.isect_hit ? bus.isect_p_hit : '0;
                end
            end
            WRITE: begin
                if (!bus.out_full) begin
                    rec_hit_d = hit_q;
                    rec_p_d   = p_hit_q;
                    rec_id_d  = tri_cnt_q;
                    // compare before incrementing so a full-width sweep never wraps
                    if (tri_cnt_q == LAST_TRI) begin
                        state_d = IDLE;
                    end else begin
                        tri_cnt_d = tri_cnt_q + 1'b1;
                        state_d   = ISSUE;
                    end
                end
            end
            FLUSH: begin
                if (!bus.out_full) begin
                    rec_hit_d    = 1'b0;
                    rec_p_d      = '0;
                    rec_id_d     = '0;
                    flush_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // record outputs show the value being written, otherwise the last one
    always_comb begin
        busy                = (state_q != IDLE);
        bus.ray_rd_en       = (state_q == IDLE) && !bus.ray_empty && !reset;
        bus.isect_start     = (state_q == ISSUE);
        bus.isect_tri_id    = tri_cnt_q;
        bus.out_wr_en       = ((state_q == WRITE) || (state_q == FLUSH))
                              && !bus.out_full;
        bus.out_hit         = rec_hit_d;
        bus.out_p_hit       = rec_p_d;
        bus.out_triangle_ID = rec_id_d;
    end

endmodule

// File: tb/tb_hit_stream_writer.sv
// Bench for hit_stream_writer: directed record tables, back-pressure,
// flush, mid-sweep reset, NUM_TRI=1 and randomized multi-ray traffic.
module tb_hit_stream_writer;
    import hit_stream_writer_pkg::*;

    localparam int DB = 32;
    localparam int MA = 2;
    localparam int NA = 4;
    localparam int MB = 12;

    typedef logic [2:0][DB-1:0] p3_t;
    typedef struct {
        logic hit;
        p3_t  p;
        int   id;
        int   cyc;
    } rec_t;
    typedef struct {
        int   delay;
        logic hit;
        p3_t  p;
        logic e_hit;
        p3_t  e_p;
        int   e_id;
    } vec_t;

    localparam p3_t ZP = '0;
    localparam p3_t PA = {32'h0000_1400, 32'hFFFF_F800, 32'h0000_0C00};
    localparam p3_t PB = {32'h0001_0000, 32'hFFFF_FC00, 32'h7FFF_FFFF};
    localparam p3_t PC = {32'h8000_0000, 32'h0000_0001, 32'h0000_0400};
    localparam p3_t PD = {32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFE_0000};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic flush_a = 1'b0;
    logic busy_a;
    logic flush_b = 1'b0;
    logic busy_b;

    hit_stream_writer_if #(.D_BITS(DB), .M_BITS(MA)) a_if ();
    hit_stream_writer_if #(.D_BITS(DB), .M_BITS(MB)) b_if ();

    hit_stream_writer #(
        .D_BITS(DB), .Q_BITS(10), .M_BITS(MA), .NUM_TRI(NA)
    ) dut_a (
        .clock(clock), .reset(reset), .flush(flush_a),
        .busy(busy_a), .bus(a_if.master)
    );

    hit_stream_writer #(
        .D_BITS(DB), .Q_BITS(10), .M_BITS(MB), .NUM_TRI(1)
    ) dut_b (
        .clock(clock), .reset(reset), .flush(flush_b),
        .busy(busy_b), .bus(b_if.master)
    );

    int checks = 0;
    int failures = 0;

    // ray FIFO models: empty when every pushed token has been popped
    int rays_pushed_a = 0;
    int rays_popped_a = 0;
    int rays_pushed_b = 0;
    int rays_popped_b = 0;
    assign a_if.ray_empty = (rays_pushed_a == rays_popped_a);
    assign b_if.ray_empty = (rays_pushed_b == rays_popped_b);
    assign b_if.out_full  = 1'b0;

    always @(posedge clock) begin
        if (a_if.ray_rd_en) rays_popped_a <= rays_popped_a + 1;
        if (b_if.ray_rd_en) rays_popped_b <= rays_popped_b + 1;
    end

    // engine model A: answers each start; logs the record the stream owes
    int   gen = 0;
    bit   dir_mode = 1'b0;
    int   dir_delay [NA];
    logic dir_hit [NA];
    p3_t  dir_p [NA];
    int   n_starts = 0;
    int   id_errs = 0;
    rec_t resp_log[$];

    initial begin : engine_a
        int   d;
        int   my_gen;
        int   eng_pos;
        int   eng_gen;
        logic h;
        p3_t  p;
        p3_t  pm;
        eng_pos = 0;
        eng_gen = 0;
        a_if.isect_done  = 1'b0;
        a_if.isect_hit   = 1'b0;
        a_if.isect_p_hit = '0;
        forever begin
            @(negedge clock);
            if (!reset && a_if.isect_start) begin
                if (eng_gen != gen) begin
                    eng_pos = 0;
                    eng_gen = gen;
                end
                my_gen = gen;
                n_starts++;
                if (int'(a_if.isect_tri_id) != eng_pos) id_errs++;
                if (dir_mode) begin
                    d = dir_delay[eng_pos];
                    h = dir_hit[eng_pos];
                    p = dir_p[eng_pos];
                end else begin
                    d = int'($urandom_range(0, 3));
                    h = 1'($urandom);
                    p = {$urandom, $urandom, $urandom};
                end
                @(posedge clock); #1;
                repeat (d) begin
                    @(posedge clock); #1;
                end
                a_if.isect_done  = 1'b1;
                a_if.isect_hit   = h;
                a_if.isect_p_hit = p;
                pm = h ? p : ZP;
                if (my_gen == gen) resp_log.push_back('{h, pm, eng_pos, 0});
                eng_pos = (eng_pos + 1) % NA;
                @(posedge clock); #1;
                a_if.isect_done  = 1'b0;
                a_if.isect_hit   = 1'b0;
                a_if.isect_p_hit = '0;
            end
        end
    end

    rec_t resp_b[$];

    initial begin : engine_b
        logic h;
        p3_t  p;
        p3_t  pm;
        b_if.isect_done  = 1'b0;
        b_if.isect_hit   = 1'b0;
        b_if.isect_p_hit = '0;
        forever begin
            @(negedge clock);
            if (!reset && b_if.isect_start) begin
                h = 1'($urandom);
                p = {$urandom, $urandom, $urandom};
                @(posedge clock); #1;
                b_if.isect_done  = 1'b1;
                b_if.isect_hit   = h;
                b_if.isect_p_hit = p;
                pm = h ? p : ZP;
                resp_b.push_back('{h, pm, 0, 0});
                @(posedge clock); #1;
                b_if.isect_done  = 1'b0;
                b_if.isect_hit   = 1'b0;
                b_if.isect_p_hit = '0;
            end
        end
    end

    rec_t got_a[$];
    rec_t got_b[$];
    int   rd_cyc[$];
    int   cyc = 0;
    int   pulse_errs = 0;

    initial begin : monitor
        logic prev_rd;
        logic prev_st;
        logic prev_wr;
        prev_rd = 1'b0;
        prev_st = 1'b0;
        prev_wr = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            if (a_if.out_wr_en)
                got_a.push_back('{a_if.out_hit, a_if.out_p_hit,
                                  int'(a_if.out_triangle_ID), cyc});
            if (b_if.out_wr_en)
                got_b.push_back('{b_if.out_hit, b_if.out_p_hit,
                                  int'(b_if.out_triangle_ID), cyc});
            if (a_if.ray_rd_en) rd_cyc.push_back(cyc);
            if ((prev_rd && a_if.ray_rd_en) || (prev_st && a_if.isect_start)
                || (prev_wr && a_if.out_wr_en))
                pulse_errs++;
            prev_rd = a_if.ray_rd_en;
            prev_st = a_if.isect_start;
            prev_wr = a_if.out_wr_en;
        end
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pk(input rec_t r);
        return {15'b0, r.hit, r.p, 16'(r.id)};
    endfunction

    function automatic rec_t got_at(input int i);
        if (i < got_a.size()) return got_a[i];
        return '{1'b1, '1, -1, -100};
    endfunction

    task automatic wait_idle_a(input int n, input string name);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (got_a.size() >= n && !busy_a && a_if.ray_empty) break;
        end
        repeat (3) @(negedge clock);
        chk(name, got_a.size(), n);
    endtask

    task automatic check_recs(input int g, input int r, input int n,
                              input string name);
        for (int i = 0; i < n; i++) begin
            rec_t e;
            if (r + i < resp_log.size()) e = resp_log[r + i];
            else e = '{1'b0, ZP, -1, 0};
            chk($sformatf("%s%0d", name, i), pk(got_at(g + i)), pk(e));
        end
    endtask

    initial begin : test
        vec_t vec [NA];
        int   g0;
        int   r0;
        int   rd0;
        int   s0;
        int   gap;
        bit   found;
        rec_t zr;

        zr = '{1'b0, ZP, 0, 0};
        vec[0] = '{2, 1'b0, PA, 1'b0, ZP, 0};
        vec[1] = '{2, 1'b1, PB, 1'b1, PB, 1};
        vec[2] = '{2, 1'b0, PC, 1'b0, ZP, 2};
        vec[3] = '{2, 1'b1, PD, 1'b1, PD, 3};

        a_if.out_full = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outs", {a_if.ray_rd_en, a_if.isect_start,
            a_if.isect_tri_id, a_if.out_wr_en, a_if.out_hit,
            a_if.out_p_hit, a_if.out_triangle_ID, busy_a}, 0);
        reset = 1'b0;

        // one ray, table-driven responses
        for (int i = 0; i < NA; i++) begin
            dir_delay[i] = vec[i].delay;
            dir_hit[i]   = vec[i].hit;
            dir_p[i]     = vec[i].p;
        end
        dir_mode = 1'b1;
        g0 = got_a.size();
        @(posedge clock); #1;
        rays_pushed_a++;
        wait_idle_a(g0 + NA, "t1_count");
        for (int i = 0; i < NA; i++)
            chk($sformatf("t1_rec%0d", i), pk(got_at(g0 + i)),
                pk('{vec[i].e_hit, vec[i].e_p, vec[i].e_id, 0}));
        chk("t1_busy", busy_a, 1'b0);
        dir_mode = 1'b0;

        // two queued rays with back-pressure on ID 2 of the first
        g0  = got_a.size();
        r0  = resp_log.size();
        rd0 = rd_cyc.size();
        @(posedge clock); #1;
        rays_pushed_a += 2;
        found = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clock);
            if (a_if.isect_done && a_if.isect_tri_id == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("t2_found", found, 1'b1);
        a_if.out_full = 1'b1;
        s0 = n_starts;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("t2_hold", {a_if.out_wr_en, busy_a}, 2'b01);
        end
        @(posedge clock); #1;
        a_if.out_full = 1'b0;
        @(negedge clock);
        chk("t2_release", {a_if.out_wr_en, a_if.out_triangle_ID},
            {1'b1, 2'd2});
        chk("t2_no_issue", n_starts, s0);
        wait_idle_a(g0 + 2 * NA, "t3_count");
        check_recs(g0, r0, 2 * NA, "t3_rec");
        chk("t3_restart", got_at(g0 + NA).id, 0);
        if (rd_cyc.size() > rd0 + 1) gap = rd_cyc[rd0 + 1] - got_at(g0 + 3).cyc;
        else gap = -1;
        chk("t3_pop_gap", gap, 1);

        // flush held with an empty ray FIFO gives a single zero record
        g0 = got_a.size();
        flush_a = 1'b1;
        repeat (20) @(negedge clock);
        chk("t4_flush_count", got_a.size(), g0 + 1);
        chk("t4_flush_rec", pk(got_at(g0)), pk(zr));
        chk("t4_flush_idle", busy_a, 1'b0);
        flush_a = 1'b0;
        repeat (2) @(negedge clock);

        // ray and flush together: sweep first, flush record after it
        g0 = got_a.size();
        r0 = resp_log.size();
        @(posedge clock); #1;
        flush_a = 1'b1;
        rays_pushed_a++;
        wait_idle_a(g0 + NA + 1, "t4_mix_count");
        check_recs(g0, r0, NA, "t4_mix_rec");
        chk("t4_mix_flush", pk(got_at(g0 + NA)), pk(zr));
        flush_a = 1'b0;

        // reset while waiting on ID 2 drops the ray
        dir_delay[0] = 0; dir_hit[0] = 1'b0; dir_p[0] = PA;
        dir_delay[1] = 0; dir_hit[1] = 1'b1; dir_p[1] = PB;
        dir_delay[2] = 8; dir_hit[2] = 1'b1; dir_p[2] = PC;
        dir_delay[3] = 0; dir_hit[3] = 1'b1; dir_p[3] = PD;
        dir_mode = 1'b1;
        g0 = got_a.size();
        @(posedge clock); #1;
        rays_pushed_a++;
        found = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clock);
            if (a_if.isect_start && a_if.isect_tri_id == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5_found", found, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        gen++;
        #1;
        chk("t5_reset_outs", {a_if.ray_rd_en, a_if.isect_start,
            a_if.isect_tri_id, a_if.out_wr_en, a_if.out_hit,
            a_if.out_p_hit, a_if.out_triangle_ID, busy_a}, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        dir_mode = 1'b0;
        repeat (15) @(negedge clock);
        chk("t5_no_partial", got_a.size(), g0 + 2);
        chk("t5_idle", busy_a, 1'b0);
        g0 = got_a.size();
        r0 = resp_log.size();
        @(posedge clock); #1;
        rays_pushed_a++;
        wait_idle_a(g0 + NA, "t5_count");
        check_recs(g0, r0, NA, "t5_rec");

        // NUM_TRI=1: each ray is one ID-0 record
        g0 = got_b.size();
        r0 = resp_b.size();
        @(posedge clock); #1;
        rays_pushed_b += 3;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (got_b.size() >= g0 + 3 && !busy_b && b_if.ray_empty) break;
        end
        repeat (3) @(negedge clock);
        chk("t6_b_count", got_b.size(), g0 + 3);
        for (int i = 0; i < 3; i++) begin
            rec_t gb;
            rec_t eb;
            gb = (g0 + i < got_b.size()) ? got_b[g0 + i] : '{1'b1, '1, -1, 0};
            eb = (r0 + i < resp_b.size()) ? resp_b[r0 + i] : '{1'b0, ZP, -1, 0};
            chk($sformatf("t6_b_rec%0d", i), pk(gb), pk(eb));
        end

        // randomized rays, response delays and record-FIFO back-pressure
        g0 = got_a.size();
        r0 = resp_log.size();
        for (int k = 0; k < 6; k++) begin
            @(posedge clock); #1;
            rays_pushed_a++;
            gap = int'($urandom_range(4, 30));
            for (int c = 0; c < gap; c++) begin
                @(posedge clock); #1;
                a_if.out_full = ($urandom_range(0, 3) == 0);
            end
        end
        @(posedge clock); #1;
        a_if.out_full = 1'b0;
        wait_idle_a(g0 + 6 * NA, "rand_count");
        check_recs(g0, r0, 6 * NA, "rand_rec");

        chk("tri_id_sequence", id_errs, 0);
        chk("pulse_width", pulse_errs, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
